// File: rtl/mc_mem_responder.sv
// mc_mem_responder: word memory behind the multicycle MIPS controller.
// It accepts a read or write strobe in IDLE and spends a programmable number
// of BUSY cycles on it. It then reports completion with a one-cycle mem_ready.
// Requests that have both strobes set or a misaligned address complete
// immediately with mem_err and do not touch the array.
module mc_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int READ_LAT    = 2,
   parameter int WRITE_LAT   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [31:0] adr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        mem_ready,
   output logic        mem_err
);

   localparam int IDX_W   = $clog2(DEPTH_WORDS);
   localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             is_wr_q, is_wr_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             commit_wr;
   logic [31:0]      mem_q [DEPTH_WORDS];

   // Upper address bits alias onto the array, so they are deliberately unused.
   logic unused_adr_bits;
   assign unused_adr_bits = ^adr[31:IDX_W+2];

   // Next-state logic: accept in IDLE, count down in BUSY, then report completion for one cycle.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      is_wr_d = is_wr_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (memread | memwrite) begin
               idx_d   = adr[IDX_W+1:2];
               wdata_d = write_data;
               is_wr_d = memwrite;
               if ((memread & memwrite) | (adr[1:0] != 2'b00)) begin
                  state_d = ERR;
               end else begin
                  state_d = BUSY;
                  cnt_d   = memwrite ? CNT_W'(WRITE_LAT) : CNT_W'(READ_LAT);
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               if (!is_wr_q) rdata_d = mem_q[idx_q];
            end
         end
         default: state_d = IDLE;  // DONE and ERR each last exactly one cycle
      endcase
   end

   // Control and result registers. An async reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         is_wr_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         is_wr_q <= is_wr_d;
         rdata_q <= rdata_d;
      end
   end

   // A write commits on the last BUSY edge. Under reset the state is IDLE, so an aborted write never lands.
   assign commit_wr = (state_q == BUSY) && (cnt_q == CNT_W'(1)) && is_wr_q;

   // Array write port.
   always_ff @(posedge clk) begin
      // NOTE: the memory array has no reset; its contents survive reset and need no clearing logic.
      if (commit_wr) mem_q[idx_q] <= wdata_q;
   end

   assign read_data = rdata_q;
   assign mem_ready = (state_q == DONE) || (state_q == ERR);
   assign mem_err   = (state_q == ERR);

endmodule

// File: tb/tb_mc_mem_responder.sv
// Self-checking bench for mc_mem_responder. It drives requests, pushes the
// expected completions to a scoreboard queue and compares them when mem_ready fires.
module tb_mc_mem_responder;

   localparam int READ_LAT  = 2;
   localparam int WRITE_LAT = 1;

   logic        clk;
   logic        reset;
   logic        memread;
   logic        memwrite;
   logic [31:0] adr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        mem_ready;
   logic        mem_err;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          lat;
   } exp_t;

   exp_t        sb_q [$];
   logic [31:0] model [256];
   logic [31:0] last_rd;
   int          n_checks;
   int          n_fail;

   mc_mem_responder #(
      .DEPTH_WORDS(256),
      .READ_LAT   (READ_LAT),
      .WRITE_LAT  (WRITE_LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .memread   (memread),
      .memwrite  (memwrite),
      .adr       (adr),
      .write_data(write_data),
      .read_data (read_data),
      .mem_ready (mem_ready),
      .mem_err   (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Waits for mem_ready (bounded), optionally moves adr mid-transaction, and checks the popped expectation.
   task automatic wait_done(input string tag, input bit chg, input int chg_at, input logic [31:0] chg_adr);
      int   n;
      exp_t e;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (chg && n == chg_at) adr = chg_adr;
      end while (!mem_ready && n < 20);
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      if (!mem_ready) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      check({tag, "_lat"},   n,         e.lat);
      check({tag, "_err"},   mem_err,   e.err);
      check({tag, "_rdata"}, read_data, e.data);
   endtask

   // One complete request: model update, scoreboard push, drive, wait, then release the strobes.
   task automatic access(input string tag, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      bit   bad;
      bad = (rd && wr) || (a[1:0] != 2'b00);
      if (bad) begin
         e.lat = 1;
      end else if (wr) begin
         model[a[9:2]] = d;
         e.lat = WRITE_LAT + 1;
      end else begin
         last_rd = model[a[9:2]];
         e.lat = READ_LAT + 1;
      end
      e.err  = bad;
      e.data = last_rd;
      sb_q.push_back(e);
      memread    = rd;
      memwrite   = wr;
      adr        = a;
      write_data = d;
      wait_done(tag, 1'b0, 0, 32'd0);
      memread  = 1'b0;
      memwrite = 1'b0;
      @(negedge clk);
      check({tag, "_pulse"}, mem_ready, 32'd0);
   endtask

   initial begin
      exp_t e;
      bit   seen;
      n_checks   = 0;
      n_fail     = 0;
      last_rd    = '0;
      reset      = 1'b1;
      memread    = 1'b0;
      memwrite   = 1'b0;
      adr        = '0;
      write_data = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", mem_ready, 32'd0);
      check("rst_err",   mem_err,   32'd0);
      check("rst_rdata", read_data, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Basic read, write-then-read, misaligned error.
      access("t1_wr", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      access("t1_rd", 1'b1, 1'b0, 32'h10, 32'h0);
      access("t2_wr", 1'b0, 1'b1, 32'h20, 32'h12345678);
      access("t2_rd", 1'b1, 1'b0, 32'h20, 32'h0);
      access("t3_mis", 1'b1, 1'b0, 32'h06, 32'h0);

      // Address wrap, then a both-strobes error that must not corrupt mem[0].
      access("t5_wr", 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
      access("t5_rd", 1'b1, 1'b0, 32'h0, 32'h0);
      access("t4_both", 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF);
      access("t4_rd", 1'b1, 1'b0, 32'h0, 32'h0);

      // Back-to-back reads with the strobe held and adr moved during BUSY.
      access("b2b_prep", 1'b0, 1'b1, 32'h24, 32'hCAFE0009);
      last_rd = model[8];
      e = '{err: 1'b0, data: model[8], lat: READ_LAT + 1};
      sb_q.push_back(e);
      memread = 1'b1;
      adr     = 32'h20;
      wait_done("b2b0", 1'b1, 1, 32'h24);
      last_rd = model[9];
      e = '{err: 1'b0, data: model[9], lat: READ_LAT + 2};
      sb_q.push_back(e);
      wait_done("b2b1", 1'b1, 2, 32'h0);
      memread = 1'b0;
      @(negedge clk);
      check("b2b_pulse", mem_ready, 32'd0);

      // Reset during cycle 1 of a read: outputs clear, no completion follows.
      memread = 1'b1;
      adr     = 32'h10;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rstmid_ready", mem_ready, 32'd0);
      check("rstmid_err",   mem_err,   32'd0);
      check("rstmid_rdata", read_data, 32'd0);
      last_rd = '0;
      @(negedge clk);
      memread = 1'b0;
      reset   = 1'b0;
      seen    = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (mem_ready) seen = 1'b1;
      end
      check("rstmid_no_ready", seen, 32'd0);
      access("rstmid_next", 1'b1, 1'b0, 32'h10, 32'h0);

      // Reset before the commit edge of a write: the old contents must survive.
      access("wabort_prep", 1'b0, 1'b1, 32'h30, 32'h11111111);
      memwrite   = 1'b1;
      adr        = 32'h30;
      write_data = 32'h22222222;
      @(negedge clk);
      reset = 1'b1;
      last_rd = '0;
      @(negedge clk);
      memwrite = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      access("wabort_rd", 1'b1, 1'b0, 32'h30, 32'h0);

      check("sb_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
